// File: rtl/axi_stream_extract_header_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_extract_header_if
// Description : Bundled input stream, payload stream and header side channel
//               for the header-extract stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_stream_extract_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_hdr;
    logic [DATA_WD-1:0]      data_hdr;
    logic [DATA_BYTE_WD-1:0] keep_hdr;
    logic                    ready_hdr;
    logic [BYTE_CNT_WD-1:0]  byte_extract_cnt;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, byte_extract_cnt, ready_out, ready_hdr,
        output ready_in, valid_out, data_out, keep_out, last_out, valid_hdr, data_hdr, keep_hdr
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, byte_extract_cnt, ready_out, ready_hdr,
        input  ready_in, valid_out, data_out, keep_out, last_out, valid_hdr, data_hdr, keep_hdr
    );
endinterface
`default_nettype wire

// File: rtl/axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_extract_header
// Description : Strips the first 1..DATA_BYTE_WD bytes of each packet onto a
//               header channel and re-aligns the remaining payload MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi_stream_extract_header_if.slave bus_io
);
    localparam int              c_CW   = BYTE_CNT_WD + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [DATA_BYTE_WD-1:0] f_keep(input logic [c_CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (i < int'(n)) k[DATA_BYTE_WD-1-i] = 1'b1;
        return k;
    endfunction

    function automatic logic [DATA_WD-1:0] f_expand(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [c_CW-1:0] f_count(input logic [DATA_BYTE_WD-1:0] k);
        logic [c_CW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) if (k[i]) c = c + c_CW'(1);
        return c;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [c_CW-1:0]         res_cnt_q, res_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    logic                    w_ready_in;
    logic [c_CW-1:0]         w_n, w_h, w_hmin, w_tot;
    logic [DATA_WD-1:0]      w_data_m;
    logic [DATA_BYTE_WD-1:0] w_hkeep;
    logic [2*DATA_WD-1:0]    w_cat;

    assign w_n      = f_count(bus_io.keep_in);
    assign w_data_m = bus_io.data_in & f_expand(bus_io.keep_in);
    assign w_h      = c_CW'(bus_io.byte_extract_cnt) + c_CW'(1);
    assign w_hmin   = (w_n < w_h) ? w_n : w_h;
    assign w_hkeep  = f_keep(w_hmin);
    assign w_tot    = res_cnt_q + w_n;
    // Residual bytes on top, incoming bytes placed right behind them.
    assign w_cat    = {res_q, {DATA_WD{1'b0}}}
                    | ({{DATA_WD{1'b0}}, w_data_m} << ((DATA_BYTE_WD - int'(res_cnt_q)) * 8));

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        hdr_valid_d = hdr_valid_q;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        w_ready_in  = 1'b0;

        if (out_valid_q && bus_io.ready_out) out_valid_d = 1'b0;
        if (hdr_valid_q && bus_io.ready_hdr) hdr_valid_d = 1'b0;

        case (state_q)
            ST_HDR: begin
                w_ready_in = !hdr_valid_q || bus_io.ready_hdr;
                if (w_ready_in && bus_io.valid_in) begin
                    hdr_valid_d = 1'b1;
                    hdr_data_d  = w_data_m & f_expand(w_hkeep);
                    hdr_keep_d  = w_hkeep;
                    res_d       = w_data_m << (int'(w_h) * 8);
                    res_cnt_d   = (w_n > w_h) ? (w_n - w_h) : '0;
                    if (bus_io.last_in && (w_n <= w_h)) state_d = ST_HDR;
                    else if (bus_io.last_in)            state_d = ST_FLUSH;
                    else                                state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                w_ready_in = !out_valid_q || bus_io.ready_out;
                if (w_ready_in && bus_io.valid_in) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w_cat[2*DATA_WD-1 -: DATA_WD];
                    if (bus_io.last_in && (w_tot <= c_FULL)) begin
                        out_keep_d = f_keep(w_tot);
                        out_last_d = 1'b1;
                        res_d      = '0;
                        res_cnt_d  = '0;
                        state_d    = ST_HDR;
                    end else begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        res_d      = w_cat[DATA_WD-1:0];
                        res_cnt_d  = w_tot - c_FULL;
                        state_d    = bus_io.last_in ? ST_FLUSH : ST_BODY;
                    end
                end
            end
            ST_FLUSH: begin
                if (!out_valid_q || bus_io.ready_out) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q;
                    out_keep_d  = f_keep(res_cnt_q);
                    out_last_d  = 1'b1;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            res_q       <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign bus_io.ready_in  = w_ready_in;
    assign bus_io.valid_out = out_valid_q;
    assign bus_io.data_out  = out_data_q;
    assign bus_io.keep_out  = out_keep_q;
    assign bus_io.last_out  = out_last_q;
    assign bus_io.valid_hdr = hdr_valid_q;
    assign bus_io.data_hdr  = hdr_data_q;
    assign bus_io.keep_hdr  = hdr_keep_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_extract_header
// Description : Byte-level packet model with directed and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_extract_header;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] pkt[$];
    beat_t      exp_hdr[$];
    beat_t      exp_pay[$];
    bit         rand_rdy, drv_first, out_stall, hdr_stall;
    int         pend;
    beat_t      held_out;
    logic [35:0] held_hdr;

    axi_stream_extract_header_if #(.DATA_WD(32)) bus ();

    axi_stream_extract_header #(.DATA_WD(32)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    function automatic beat_t mk_beat(input int start, input int cnt, input logic lst);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = lst;
        for (int i = 0; i < cnt; i++) begin
            b.data[31-8*i -: 8] = pkt[start+i];
            b.keep[3-i]         = 1'b1;
        end
        return b;
    endfunction

    // Header = first min(H,L) bytes; payload = the rest, cut into 4-byte beats.
    task automatic model_packet(input int h);
        int len = pkt.size();
        int nh  = (h < len) ? h : len;
        exp_hdr.push_back(mk_beat(0, nh, 1'b0));
        for (int s = h; s < len; s += 4) begin
            int c = (len - s < 4) ? (len - s) : 4;
            exp_pay.push_back(mk_beat(s, c, (s + c) == len));
        end
    endtask

    task automatic mon_step();
        beat_t e;
        if (!rst_n) begin
            out_stall = 0;
            hdr_stall = 0;
            return;
        end
        if (out_stall)
            chk("out_hold", 64'({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out}),
                64'({1'b1, held_out}));
        if (hdr_stall)
            chk("hdr_hold", 64'({bus.valid_hdr, bus.data_hdr, bus.keep_hdr}), 64'({1'b1, held_hdr}));
        if (bus.valid_out && bus.ready_out) begin
            if (exp_pay.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL payload_unexpected: actual=%h required=no beat", bus.data_out);
            end else begin
                e = exp_pay.pop_front();
                chk("payload", 64'({bus.data_out, bus.keep_out, bus.last_out}), 64'(e));
            end
        end
        if (bus.valid_hdr && bus.ready_hdr) begin
            if (exp_hdr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL header_unexpected: actual=%h required=no header", bus.data_hdr);
            end else begin
                e = exp_hdr.pop_front();
                chk("header", 64'({bus.data_hdr, bus.keep_hdr}), 64'({e.data, e.keep}));
            end
        end
        if (bus.valid_in) begin
            if (!drv_first)
                chk("ready_in_body", 64'(bus.ready_in), 64'(!bus.valid_out || bus.ready_out));
            else if (bus.valid_hdr && !bus.ready_hdr)
                chk("ready_in_hdr_block", 64'(bus.ready_in), 64'(0));
        end
        out_stall = bus.valid_out && !bus.ready_out;
        held_out  = {bus.data_out, bus.keep_out, bus.last_out};
        hdr_stall = bus.valid_hdr && !bus.ready_hdr;
        held_hdr  = {bus.data_hdr, bus.keep_hdr};
    endtask

    task automatic wait_neg();
        @(negedge clk);
        if (pend == 1) chk("hdr_latency", 64'(bus.valid_hdr), 64'(1));
        if (pend == 2) chk("out_latency", 64'(bus.valid_out), 64'(1));
        pend = 0;
    endtask

    task automatic send_packet(input int h, input int nb_lim, input bit push, input bit gaps);
        int len = pkt.size();
        int nb  = (len + 3) / 4;
        logic [31:0] d;
        logic [3:0]  kp;
        int to;
        if (push) model_packet(h);
        for (int k = 0; k < nb && k < nb_lim; k++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    bus.valid_in = 1'b0;
                    wait_neg();
                    @(posedge clk); #1;
                end
            for (int i = 0; i < 4; i++) begin
                int idx = k * 4 + i;
                if (idx < len) begin
                    d[31-8*i -: 8] = pkt[idx];
                    kp[3-i]        = 1'b1;
                end else begin
                    d[31-8*i -: 8] = 8'($urandom);
                    kp[3-i]        = 1'b0;
                end
            end
            bus.valid_in         = 1'b1;
            bus.data_in          = d;
            bus.keep_in          = kp;
            bus.last_in          = (k == nb - 1);
            bus.byte_extract_cnt = (k == 0) ? 2'(h - 1) : 2'($urandom);
            drv_first            = (k == 0);
            to = 0;
            forever begin
                wait_neg();
                if (bus.ready_in) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                to++;
                if (to > 1000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL handshake_timeout: actual=ready_in low required=accept within 1000 cycles");
                    bus.valid_in = 1'b0;
                    drv_first    = 1;
                    return;
                end
            end
            pend = (k == 0) ? 1 : 2;
        end
        bus.valid_in = 1'b0;
        drv_first    = 1;
    endtask

    task automatic drain();
        rand_rdy      = 0;
        bus.ready_out = 1'b1;
        bus.ready_hdr = 1'b1;
        for (int i = 0; i < 300 && (exp_hdr.size() != 0 || exp_pay.size() != 0); i++) begin
            wait_neg();
            @(posedge clk); #1;
        end
        wait_neg();
        @(posedge clk); #1;
        chk("drain_hdr_left", 64'(exp_hdr.size()), 64'(0));
        chk("drain_pay_left", 64'(exp_pay.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid_in = 0; bus.data_in = 0; bus.keep_in = 0; bus.last_in = 0;
        bus.byte_extract_cnt = 0; bus.ready_out = 1; bus.ready_hdr = 1;
        rand_rdy = 0; drv_first = 1; pend = 0; out_stall = 0; hdr_stall = 0;
        held_out = '0; held_hdr = '0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk); #1;
                if (rand_rdy) begin
                    bus.ready_out = ($urandom_range(0, 3) != 0);
                    bus.ready_hdr = ($urandom_range(0, 2) != 0);
                end
            end
        join_none

        // Reset state
        @(negedge clk);
        chk("rst_valid_out", 64'(bus.valid_out), 64'(0));
        chk("rst_valid_hdr", 64'(bus.valid_hdr), 64'(0));
        chk("rst_out_regs", 64'({bus.data_out, bus.keep_out, bus.last_out}), 64'(0));
        chk("rst_hdr_regs", 64'({bus.data_hdr, bus.keep_hdr}), 64'(0));
        chk("rst_ready_in", 64'(bus.ready_in), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // H=2, payload realigned by two bytes
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_packet(2);
        chk("pin1_hdr", 64'({exp_hdr[0].data, exp_hdr[0].keep}), 64'({32'hAABB0000, 4'b1100}));
        chk("pin1_p0", 64'(exp_pay[0]), 64'({32'hCCDD1122, 4'b1111, 1'b0}));
        chk("pin1_p1", 64'(exp_pay[1]), 64'({32'h33445566, 4'b1111, 1'b1}));
        send_packet(2, 99, 0, 0);
        drain();

        // H=1, tail needs a flush beat
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        model_packet(1);
        chk("pin2_hdr", 64'({exp_hdr[0].data, exp_hdr[0].keep}), 64'({32'h01000000, 4'b1000}));
        chk("pin2_p0", 64'(exp_pay[0]), 64'({32'h02030405, 4'b1111, 1'b0}));
        chk("pin2_p1", 64'(exp_pay[1]), 64'({32'h06070000, 4'b1100, 1'b1}));
        send_packet(1, 99, 0, 0);
        drain();

        // H=4, pass-through
        pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        model_packet(4);
        chk("pin3_hdr", 64'({exp_hdr[0].data, exp_hdr[0].keep}), 64'({32'hA0A1A2A3, 4'b1111}));
        chk("pin3_p1", 64'(exp_pay[1]), 64'({32'hC0C1C2C3, 4'b1111, 1'b1}));
        send_packet(4, 99, 0, 0);
        drain();

        // Header-only packet
        pkt = '{8'hDE, 8'hAD};
        model_packet(4);
        chk("pin4_hdr", 64'({exp_hdr[0].data, exp_hdr[0].keep}), 64'({32'hDEAD0000, 4'b1100}));
        chk("pin4_no_pay", 64'(exp_pay.size()), 64'(0));
        send_packet(4, 99, 0, 0);
        wait_neg();
        chk("t4_ready_next", 64'(bus.ready_in), 64'(1));
        @(posedge clk); #1;
        drain();

        // Back-pressure on both channels
        bus.ready_out = 1'b0;
        bus.ready_hdr = 1'b0;
        pkt.delete();
        for (int i = 0; i < 12; i++) pkt.push_back(8'(8'h40 + i));
        fork
            begin
                send_packet(2, 99, 1, 0);
                pkt.delete();
                for (int i = 0; i < 6; i++) pkt.push_back(8'(8'h90 + i));
                send_packet(3, 99, 1, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.ready_out = 1'b1;
                repeat (4) @(posedge clk);
                #1 bus.ready_hdr = 1'b1;
            end
        join
        drain();

        // Asynchronous reset in the middle of a packet
        bus.ready_out = 1'b0;
        bus.ready_hdr = 1'b0;
        pkt.delete();
        for (int i = 0; i < 12; i++) pkt.push_back(8'(8'h70 + i));
        send_packet(2, 2, 0, 0);
        wait_neg();
        chk("t6_hdr_before", 64'(bus.valid_hdr), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid_out", 64'(bus.valid_out), 64'(0));
        chk("t6_rst_valid_hdr", 64'(bus.valid_hdr), 64'(0));
        exp_hdr.delete();
        exp_pay.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.ready_out = 1'b1;
        bus.ready_hdr = 1'b1;
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        model_packet(3);
        chk("pin6_hdr", 64'({exp_hdr[0].data, exp_hdr[0].keep}), 64'({32'h31323300, 4'b1110}));
        send_packet(3, 99, 0, 0);
        drain();

        // Randomized traffic
        rand_rdy = 1;
        for (int p = 0; p < 80; p++) begin
            int len = $urandom_range(1, 14);
            int h   = $urandom_range(1, 4);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            send_packet(h, 99, 1, 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
